// File: rtl/rename_recovery_ctrl.sv
// Rename-state recovery sequencer: after a flush it issues a one-cycle freelist
// rollback, then walks the surviving ROB entries oldest-first, two per cycle.
module rename_recovery_ctrl #(
  parameter int ROB_DEPTH = 64,
  parameter int ROB_IDX_W = 6,
  parameter int PREG_W    = 6
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic                 flush_valid,
  input  logic [ROB_IDX_W:0]   flush_robptr,
  input  logic [ROB_IDX_W:0]   rob_head_ptr,
  output logic [ROB_IDX_W-1:0] rob_rd_idx0,
  output logic [ROB_IDX_W-1:0] rob_rd_idx1,
  input  logic                 rob_rd_has_dest0,
  input  logic                 rob_rd_has_dest1,
  input  logic [PREG_W-1:0]    rob_rd_prd0,
  input  logic [PREG_W-1:0]    rob_rd_prd1,
  output logic                 is_idle,
  output logic                 is_rollingback,
  output logic                 is_walking,
  output logic                 walking_valid0,
  output logic                 walking_valid1,
  output logic [PREG_W-1:0]    walking_old_prd0,
  output logic [PREG_W-1:0]    walking_old_prd1,
  output logic                 recovery_busy,
  output logic                 walk_done
);

  localparam int PTR_W = ROB_IDX_W + 1;

  if (ROB_DEPTH != (1 << ROB_IDX_W)) begin : g_bad_depth
    $error("ROB_DEPTH must equal 2**ROB_IDX_W");
  end

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_ROLLBACK = 2'd1,
    ST_WALK     = 2'd2
  } state_t;

  state_t           state, state_next;
  logic [PTR_W-1:0] walk_ptr, walk_ptr_next;
  logic [PTR_W-1:0] remaining, remaining_next;
  logic [PTR_W-1:0] step;
  logic             walk_done_next;
  logic             in_range0, in_range1;

  // Pointers carry a wrap bit, so the plain difference is the survivor count,
  // and a full ROB (same index, opposite wrap) yields exactly ROB_DEPTH.
  assign in_range0 = (remaining != '0);
  assign in_range1 = (remaining >= PTR_W'(2));
  assign step      = in_range1 ? PTR_W'(2) : (in_range0 ? PTR_W'(1) : '0);

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values; combinational logic below uses blocking assignments.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state     <= ST_IDLE;
      walk_ptr  <= '0;
      remaining <= '0;
      walk_done <= 1'b0;
    end else begin
      state     <= state_next;
      walk_ptr  <= walk_ptr_next;
      remaining <= remaining_next;
      walk_done <= walk_done_next;
    end
  end

  // NOTE: every signal gets a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_next     = state;
    walk_ptr_next  = walk_ptr;
    remaining_next = remaining;
    walk_done_next = 1'b0;
    if (flush_valid) begin
      // A new flush overrides whatever recovery was in flight.
      state_next     = ST_ROLLBACK;
      walk_ptr_next  = rob_head_ptr;
      remaining_next = flush_robptr - rob_head_ptr;
    end else begin
      case (state)
        ST_ROLLBACK: begin
          if (remaining == '0) begin
            state_next     = ST_IDLE;
            walk_done_next = 1'b1;
          end else begin
            state_next = ST_WALK;
          end
        end
        ST_WALK: begin
          walk_ptr_next  = walk_ptr + step;
          remaining_next = remaining - step;
          if (remaining <= PTR_W'(2)) begin
            state_next     = ST_IDLE;
            walk_done_next = 1'b1;
          end
        end
        default: state_next = ST_IDLE;
      endcase
    end
  end

  assign is_idle        = (state == ST_IDLE);
  assign is_rollingback = (state == ST_ROLLBACK);
  assign is_walking     = (state == ST_WALK);
  assign recovery_busy  = !is_idle;

  assign rob_rd_idx0 = walk_ptr[ROB_IDX_W-1:0];
  // Lane 1 reads the next entry, wrapping at ROB_DEPTH; forced to 0 while
  // reset is held so both read addresses come up quiet.
  assign rob_rd_idx1 = reset_n ? (walk_ptr[ROB_IDX_W-1:0] + ROB_IDX_W'(1)) : '0;

  // Entries without a destination still consume a walk slot but restore nothing.
  assign walking_valid0   = is_walking & in_range0 & rob_rd_has_dest0;
  assign walking_valid1   = is_walking & in_range1 & rob_rd_has_dest1;
  assign walking_old_prd0 = walking_valid0 ? rob_rd_prd0 : '0;
  assign walking_old_prd1 = walking_valid1 ? rob_rd_prd1 : '0;

endmodule

// File: tb/tb_rename_recovery_ctrl.sv
// Scoreboard bench for rename_recovery_ctrl: flushes push expected per-cycle
// events; a negedge monitor pops and compares whenever recovery activity shows.
module tb_rename_recovery_ctrl;

  localparam int ROB_IDX_W = 6;
  localparam int PREG_W    = 6;
  localparam int DEPTH     = 64;

  localparam int K_RB   = 1;
  localparam int K_WALK = 2;
  localparam int K_DONE = 3;

  typedef struct {
    int kind;
    int cyc;
    int idx0;
    int idx1;
    int v0;
    int v1;
    int p0;
    int p1;
  } exp_t;

  logic                 clock = 1'b0;
  logic                 reset_n = 1'b0;
  logic                 flush_valid = 1'b0;
  logic [ROB_IDX_W:0]   flush_robptr = '0;
  logic [ROB_IDX_W:0]   rob_head_ptr = '0;
  logic [ROB_IDX_W-1:0] rob_rd_idx0, rob_rd_idx1;
  logic                 rob_rd_has_dest0, rob_rd_has_dest1;
  logic [PREG_W-1:0]    rob_rd_prd0, rob_rd_prd1;
  logic                 is_idle, is_rollingback, is_walking;
  logic                 walking_valid0, walking_valid1;
  logic [PREG_W-1:0]    walking_old_prd0, walking_old_prd1;
  logic                 recovery_busy, walk_done;

  logic              rob_dest [DEPTH];
  logic [PREG_W-1:0] rob_prd  [DEPTH];

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_fail = 0;
  int   cyc = 0;
  logic mon_en = 1'b0;

  rename_recovery_ctrl #(
    .ROB_DEPTH(DEPTH), .ROB_IDX_W(ROB_IDX_W), .PREG_W(PREG_W)
  ) dut (
    .clock(clock), .reset_n(reset_n),
    .flush_valid(flush_valid), .flush_robptr(flush_robptr), .rob_head_ptr(rob_head_ptr),
    .rob_rd_idx0(rob_rd_idx0), .rob_rd_idx1(rob_rd_idx1),
    .rob_rd_has_dest0(rob_rd_has_dest0), .rob_rd_has_dest1(rob_rd_has_dest1),
    .rob_rd_prd0(rob_rd_prd0), .rob_rd_prd1(rob_rd_prd1),
    .is_idle(is_idle), .is_rollingback(is_rollingback), .is_walking(is_walking),
    .walking_valid0(walking_valid0), .walking_valid1(walking_valid1),
    .walking_old_prd0(walking_old_prd0), .walking_old_prd1(walking_old_prd1),
    .recovery_busy(recovery_busy), .walk_done(walk_done)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  // Combinational ROB read port model.
  assign rob_rd_has_dest0 = rob_dest[rob_rd_idx0];
  assign rob_rd_has_dest1 = rob_dest[rob_rd_idx1];
  assign rob_rd_prd0      = rob_prd[rob_rd_idx0];
  assign rob_rd_prd1      = rob_prd[rob_rd_idx1];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    n_cmp++;
    if (act !== want) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, want);
    end
  endtask

  task automatic sync();
    @(posedge clock);
    #1;
  endtask

  task automatic push(input int kind, input int c, input int i0, input int i1,
                      input int v0, input int v1, input int p0, input int p1);
    exp_t e;
    e.kind = kind; e.cyc = c; e.idx0 = i0; e.idx1 = i1;
    e.v0 = v0; e.v1 = v1; e.p0 = p0; e.p1 = p1;
    exp_q.push_back(e);
  endtask

  // Issues a one-cycle flush; returns the flush cycle T and leaves time at T+1.
  task automatic flush(input logic [ROB_IDX_W:0] head, input logic [ROB_IDX_W:0] fptr,
                       output int t);
    flush_valid  = 1'b1;
    rob_head_ptr = head;
    flush_robptr = fptr;
    t = cyc;
    sync();
    flush_valid = 1'b0;
  endtask

  // Expected rollback + first ncyc walk cycles (+ done if with_done) from ROB contents.
  task automatic push_walks(input int head, input int n, input int t,
                            input int ncyc, input bit with_done);
    int total;
    total = (n + 1) / 2;
    push(K_RB, t + 1, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < total && i < ncyc; i++) begin
      int e0, e1, v0, v1, p0, p1;
      e0 = (head + 2 * i) % DEPTH;
      e1 = (head + 2 * i + 1) % DEPTH;
      v0 = int'(rob_dest[e0]);
      v1 = (2 * i + 1 < n) ? int'(rob_dest[e1]) : 0;
      p0 = (v0 != 0) ? int'(rob_prd[e0]) : 0;
      p1 = (v1 != 0) ? int'(rob_prd[e1]) : 0;
      push(K_WALK, t + 2 + i, e0, e1, v0, v1, p0, p1);
    end
    if (with_done) push(K_DONE, t + 2 + total, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic drain(input string name, input int budget);
    for (int i = 0; i < budget && exp_q.size() != 0; i++) sync();
    check(name, exp_q.size(), 0);
    repeat (3) sync();
  endtask

  // Monitor: compares every cycle that shows recovery activity against the queue.
  always @(negedge clock) begin
    if (reset_n && mon_en) begin
      check("busy_vs_idle", recovery_busy, !is_idle);
      check("state_onehot", int'(is_idle) + int'(is_rollingback) + int'(is_walking), 1);
      if (!is_walking)
        check("lanes_quiet", {walking_valid1, walking_valid0, walking_old_prd1, walking_old_prd0}, 0);
      if (walk_done || is_rollingback || is_walking) begin
        int   kind;
        exp_t e;
        kind = walk_done ? K_DONE : (is_rollingback ? K_RB : K_WALK);
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_fail++;
          $display("FAIL unexpected_event: got kind %0d at cycle %0d, expected none", kind, cyc);
        end else begin
          e = exp_q.pop_front();
          check($sformatf("kind@%0d", cyc), kind, e.kind);
          check($sformatf("cycle_of_kind%0d", e.kind), cyc, e.cyc);
          if (e.kind == K_WALK) begin
            check($sformatf("idx0@%0d", cyc), rob_rd_idx0, e.idx0);
            check($sformatf("idx1@%0d", cyc), rob_rd_idx1, e.idx1);
            check($sformatf("valid0@%0d", cyc), walking_valid0, e.v0);
            check($sformatf("valid1@%0d", cyc), walking_valid1, e.v1);
            check($sformatf("prd0@%0d", cyc), walking_old_prd0, e.p0);
            check($sformatf("prd1@%0d", cyc), walking_old_prd1, e.p1);
          end else if (e.kind == K_DONE) begin
            check($sformatf("idle_with_done@%0d", cyc), is_idle, 1);
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected bench completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int t, t2;
    for (int i = 0; i < DEPTH; i++) begin
      rob_dest[i] = (i % 3 != 1);
      rob_prd[i]  = PREG_W'((i * 5 + 7) % DEPTH);
    end
    // Directed window for the 10..15 walk; 11 and 15 carry bait data.
    rob_dest[10] = 1'b1; rob_prd[10] = 6'd40;
    rob_dest[11] = 1'b0; rob_prd[11] = 6'd41;
    rob_dest[12] = 1'b1; rob_prd[12] = 6'd42;
    rob_dest[13] = 1'b1; rob_prd[13] = 6'd43;
    rob_dest[14] = 1'b1; rob_prd[14] = 6'd44;
    rob_dest[15] = 1'b1; rob_prd[15] = 6'd45;
    // Wrap window 62,63,0,1; entry 1 is outside the walk and must stay gated.
    rob_dest[62] = 1'b1; rob_prd[62] = 6'd17;
    rob_dest[63] = 1'b1; rob_prd[63] = 6'd18;
    rob_dest[0]  = 1'b1; rob_prd[0]  = 6'd19;
    rob_dest[1]  = 1'b1; rob_prd[1]  = 6'd20;

    // Reset values while reset is held.
    repeat (3) @(posedge clock);
    #1;
    check("rst_is_idle", is_idle, 1);
    check("rst_busy", recovery_busy, 0);
    check("rst_walk_done", walk_done, 0);
    check("rst_idx", {rob_rd_idx1, rob_rd_idx0}, 0);
    check("rst_other", {is_rollingback, is_walking, walking_valid1, walking_valid0}, 0);
    reset_n = 1'b1;
    mon_en  = 1'b1;
    repeat (5) sync();
    check("idle_is_idle", is_idle, 1);
    check("idle_busy", recovery_busy, 0);
    check("idle_valids_done", {walking_valid1, walking_valid0, walk_done}, 0);

    // Empty survivor set: rollback then straight to idle with walk_done.
    flush(7'd3, 7'd3, t);
    push(K_RB, t + 1, 0, 0, 0, 0, 0, 0);
    push(K_DONE, t + 2, 0, 0, 0, 0, 0, 0);
    drain("drain_empty", 10);

    // Five survivors at 10..14, hand-computed.
    flush(7'd10, 7'd15, t);
    push(K_RB,   t + 1, 0, 0, 0, 0, 0, 0);
    push(K_WALK, t + 2, 10, 11, 1, 0, 40, 0);
    push(K_WALK, t + 3, 12, 13, 1, 1, 42, 43);
    push(K_WALK, t + 4, 14, 15, 1, 0, 44, 0);
    push(K_DONE, t + 5, 0, 0, 0, 0, 0, 0);
    drain("drain_five", 12);

    // Index wrap: 62,63,0 survive.
    flush(7'b0_111110, 7'b1_000001, t);
    push(K_RB,   t + 1, 0, 0, 0, 0, 0, 0);
    push(K_WALK, t + 2, 62, 63, 1, 1, 17, 18);
    push(K_WALK, t + 3, 0, 1, 1, 0, 19, 0);
    push(K_DONE, t + 4, 0, 0, 0, 0, 0, 0);
    drain("drain_wrap", 10);

    // Flush in the 3rd walk cycle of a 20-entry walk restarts recovery.
    flush(7'd0, 7'd20, t);
    push_walks(0, 20, t, 3, 1'b0);
    repeat (3) sync();
    flush(7'd0, 7'd4, t2);
    check("midwalk_flush_cycle", t2, t + 4);
    push_walks(0, 4, t2, 2, 1'b1);
    drain("drain_midwalk", 12);

    // Flush in the final walk cycle wins: no walk_done for the first walk.
    flush(7'd20, 7'd24, t);
    push_walks(20, 4, t, 2, 1'b0);
    repeat (2) sync();
    flush(7'd30, 7'd31, t2);
    push_walks(30, 1, t2, 1, 1'b1);
    drain("drain_lastcycle", 12);

    // Full ROB: every entry walked, starting at 5.
    flush(7'b0_000101, 7'b1_000101, t);
    push_walks(5, 64, t, 32, 1'b1);
    drain("drain_full", 45);

    // Reset mid-walk: back to idle at once, no walk_done afterwards.
    flush(7'd0, 7'd40, t);
    push_walks(0, 40, t, 1, 1'b0);
    repeat (2) sync();
    reset_n = 1'b0;
    #1;
    check("rstwalk_idle", is_idle, 1);
    check("rstwalk_done", walk_done, 0);
    check("rstwalk_idx", {rob_rd_idx1, rob_rd_idx0}, 0);
    repeat (2) sync();
    reset_n = 1'b1;
    repeat (5) sync();
    check("rstwalk_still_idle", is_idle, 1);
    drain("drain_rstwalk", 5);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
